cacheline_burst_adapter: RTL and testbench

- Sits between the cache/eviction write buffer side and physical memory.
- Converts one full-line request (read fill or dirty writeback) into a fixed-length burst of BEAT_W-wide memory beats, then collects read beats back into a line.
- Runs one line transaction at a time.
- Issues a single-cycle line_resp to the requester on completion.

---
 rtl/cache_mem_pkg.sv | 21 ++
 rtl/burst_beat_counter.sv | 31 +++
 rtl/cacheline_burst_adapter.sv | 146 ++++++++++++++
 tb/tb_cacheline_burst_adapter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared constants and types for the cache-to-memory burst adapter.
package cache_mem_pkg;

  // Default geometry: 128-bit line over a 32-bit memory bus.
  localparam int DEFAULT_LINE_W = 128;
  localparam int DEFAULT_BEAT_W = 32;
  localparam int DEFAULT_ADDR_W = 32;

  // Values derived from the default geometry.
  localparam int BEATS       = DEFAULT_LINE_W / DEFAULT_BEAT_W;
  localparam int OFFSET_BITS = $clog2(DEFAULT_LINE_W / 8);

  // Adapter controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    DONE     = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index within a line burst, with a last-beat flag.
// Clearing has priority over incrementing; incrementing on the last beat
// wraps the index back to zero.
module burst_beat_counter #(
  parameter int BEATS = 4,
  parameter int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  assign last = (count == LAST_IDX);

  // Beat index register: clear on new transaction, advance on each accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Converts one full cacheline request (fill or writeback) into a fixed-length
// burst of memory beats, and reassembles read beats into a line.
//
// Handshake: line_read/line_write are level requests held by the requester
// until line_resp; line_resp pulses for one cycle per completed line.
// On the memory side pmem_read/pmem_write stay high for the whole burst and
// each cycle with pmem_resp high completes exactly one beat (write beat
// accepted, or read beat valid on pmem_rdata). pmem_resp outside a burst is
// ignored.
module cacheline_burst_adapter
  import cache_mem_pkg::*;
#(
  parameter int LINE_W = DEFAULT_LINE_W,
  parameter int BEAT_W = DEFAULT_BEAT_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 line_read,
  input  logic                                 line_write,
  input  logic [ADDR_W-1:0]                    line_address,
  input  logic [LINE_W-1:0]                    line_wdata,
  output logic [LINE_W-1:0]                    line_rdata,
  output logic                                 line_resp,
  output logic                                 pmem_read,
  output logic                                 pmem_write,
  output logic [ADDR_W-1:0]                    pmem_address,
  output logic [BEAT_W-1:0]                    pmem_wdata,
  input  logic [BEAT_W-1:0]                    pmem_rdata,
  input  logic                                 pmem_resp,
  output logic [1:0]                           dbg_state,
  output logic [$clog2(LINE_W/BEAT_W)-1:0]     dbg_count
);

  localparam int NUM_BEATS = LINE_W / BEAT_W;
  localparam int CNT_W     = $clog2(NUM_BEATS);
  localparam int OFF_BITS  = $clog2(LINE_W / 8);

  adapter_state_t    state;
  adapter_state_t    state_nxt;
  logic [LINE_W-1:0] wr_shift;
  logic [ADDR_W-1:0] aligned_addr;
  logic [CNT_W-1:0]  beat_idx;
  logic              beat_last;
  logic              accept_wr;
  logic              accept_rd;
  logic              accept;
  logic              in_burst;
  logic              beat_done;

  // Write wins over read when both are requested in the same idle cycle.
  assign accept_wr = (state == IDLE) && line_write;
  assign accept_rd = (state == IDLE) && !line_write && line_read;
  assign accept    = accept_wr || accept_rd;
  assign in_burst  = (state == WR_BURST) || (state == RD_BURST);
  assign beat_done = in_burst && pmem_resp;

  // Line-aligned address: drop the byte offset within the line.
  always_comb begin
    aligned_addr               = line_address;
    aligned_addr[OFF_BITS-1:0] = '0;
  end

  burst_beat_counter #(
    .BEATS (NUM_BEATS),
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (beat_done),
    .count (beat_idx),
    .last  (beat_last)
  );

  // Next-state selection for the line transaction controller.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (line_write) begin
          state_nxt = WR_BURST;
        end else if (line_read) begin
          state_nxt = RD_BURST;
        end
      end
      WR_BURST, RD_BURST: begin
        if (pmem_resp && beat_last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst address is captured once at acceptance and held for the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmem_address <= '0;
    end else if (accept) begin
      pmem_address <= aligned_addr;
    end
  end

  // Writeback shift register: low beat is always the one on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_shift <= '0;
    end else if (accept_wr) begin
      wr_shift <= line_wdata;
    end else if ((state == WR_BURST) && pmem_resp) begin
      wr_shift <= wr_shift >> BEAT_W;
    end
  end

  // Fill assembly: each valid read beat lands in its slice of the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_rdata <= '0;
    end else if ((state == RD_BURST) && pmem_resp) begin
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (beat_idx == CNT_W'(b)) begin
          line_rdata[b*BEAT_W +: BEAT_W] <= pmem_rdata;
        end
      end
    end
  end

  assign pmem_write = (state == WR_BURST);
  assign pmem_read  = (state == RD_BURST);
  assign pmem_wdata = wr_shift[BEAT_W-1:0];
  assign line_resp  = (state == DONE);
  assign dbg_state  = state;
  assign dbg_count  = beat_idx;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Testbench for cacheline_burst_adapter: directed scenarios plus randomized
// line traffic against a line-level reference model.
module tb_cacheline_burst_adapter;
  import cache_mem_pkg::*;

  localparam int LW = DEFAULT_LINE_W;
  localparam int BW = DEFAULT_BEAT_W;
  localparam int AW = DEFAULT_ADDR_W;
  localparam int NB = LW / BW;
  localparam int CW = $clog2(NB);
  localparam int LINE_BYTES = LW / 8;

  logic          clk;
  logic          rst;
  logic          line_read;
  logic          line_write;
  logic [AW-1:0] line_address;
  logic [LW-1:0] line_wdata;
  logic [LW-1:0] line_rdata;
  logic          line_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_count;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];
  logic [LW-1:0] last_fill;

  cacheline_burst_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One line transaction, driven from the current negedge. The bench plays
  // requester and memory; stall is the gap before each beat (random up to
  // stall when rnd_stall). fixed_rd returns beats 0x11111111*(n+1).
  task automatic run_txn(input bit wr, input bit rd, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, input int stall,
                         input bit rnd_stall, input bit fixed_rd, input bit keep_rd,
                         output int cycles);
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_line;
    logic [BW-1:0] v;
    bit is_wr;
    bit got;
    int gap;
    int target;
    int n_beats;
    is_wr    = wr;
    exp_addr = (addr / LINE_BYTES) * LINE_BYTES;
    exp_line = last_fill;
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      if (is_wr) begin
        exp_q.push_back(wdata[b*BW +: BW]);
      end else begin
        v = fixed_rd ? BW'(32'h1111_1111 * (b + 1)) : BW'($urandom);
        exp_q.push_back(v);
        exp_line[b*BW +: BW] = v;
      end
    end
    line_address = addr;
    line_wdata   = wdata;
    if (wr) line_write = 1'b1;
    if (rd) line_read = 1'b1;
    cycles  = 0;
    got     = 0;
    gap     = 0;
    n_beats = 0;
    target  = rnd_stall ? $urandom_range(0, stall) : stall;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      cycles++;
      if (line_resp) begin
        got = 1;
        checks++;
        if (n_beats !== NB) begin
          errors++;
          $display("FAIL beat_count: got %0d beats, required %0d", n_beats, NB);
        end
        checks++;
        if (!is_wr && line_rdata !== exp_line) begin
          errors++;
          $display("FAIL fill_data: line_rdata=%h required %h", line_rdata, exp_line);
        end else if (is_wr && line_rdata !== last_fill) begin
          errors++;
          $display("FAIL wr_keeps_rdata: line_rdata=%h required %h", line_rdata, last_fill);
        end
        if (!is_wr) last_fill = exp_line;
        line_write = 1'b0;
        if (!keep_rd) line_read = 1'b0;
        pmem_resp = 1'b0;
      end else if (cyc == 0) begin
        // Idle cycle: a stray memory response must not matter.
        pmem_resp  = 1'($urandom);
        pmem_rdata = BW'($urandom);
      end else begin
        checks++;
        if (pmem_write !== is_wr || pmem_read !== !is_wr || pmem_address !== exp_addr) begin
          errors++;
          $display("FAIL burst_bus: wr=%b rd=%b addr=%h required wr=%b rd=%b addr=%h",
                   pmem_write, pmem_read, pmem_address, is_wr, !is_wr, exp_addr);
        end
        pmem_resp  = 1'b0;
        pmem_rdata = BW'($urandom);
        if (gap >= target && exp_q.size() > 0) begin
          pmem_resp = 1'b1;
          gap       = 0;
          target    = rnd_stall ? $urandom_range(0, stall) : stall;
          n_beats++;
          if (is_wr) begin
            checks++;
            if (pmem_wdata !== exp_q[0]) begin
              errors++;
              $display("FAIL wr_beat%0d: pmem_wdata=%h required %h", n_beats - 1, pmem_wdata, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end else begin
            pmem_rdata = exp_q.pop_front();
          end
        end else begin
          gap++;
        end
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: line_resp not seen, required within 400 cycles");
      line_write = 1'b0;
      line_read  = 1'b0;
      pmem_resp  = 1'b0;
    end
    // line_resp must be a single-cycle pulse.
    checks++;
    if (line_resp !== 1'b0) begin
      errors++;
      $display("FAIL resp_pulse: line_resp=%b required 0 after pulse", line_resp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (pmem_read !== 0 || pmem_write !== 0 || line_resp !== 0 || pmem_address !== '0 ||
        pmem_wdata !== '0 || line_rdata !== '0 || dbg_state !== IDLE || dbg_count !== '0) begin
      errors++;
      $display("FAIL %s: rd=%b wr=%b resp=%b addr=%h wd=%h rdata=%h st=%0d cnt=%0d required all 0",
               tag, pmem_read, pmem_write, line_resp, pmem_address, pmem_wdata,
               line_rdata, dbg_state, dbg_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    line_read = 0; line_write = 0; line_address = '0; line_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    last_fill = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spurious_resp();
    pmem_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== IDLE || dbg_count !== '0 || pmem_read !== 0 || pmem_write !== 0 || line_resp !== 0) begin
        errors++;
        $display("FAIL spurious_resp: st=%0d cnt=%0d rd=%b wr=%b resp=%b required idle/0",
                 dbg_state, dbg_count, pmem_read, pmem_write, line_resp);
      end
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_writeback();
    int cyc;
    run_txn(1, 0, 32'h0000_1044, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 0, 0, 0, 0, cyc);
    checks++;
    if (cyc !== NB + 2) begin
      errors++;
      $display("FAIL wb_latency: request cycles=%0d required %0d", cyc, NB + 2);
    end
  endtask

  task automatic test_fill_stalls();
    int cyc;
    run_txn(0, 1, 32'h0000_2000, '0, 2, 0, 1, 0, cyc);
    checks++;
    if (line_rdata !== 128'h44444444_33333333_22222222_11111111) begin
      errors++;
      $display("FAIL fill_stalls: line_rdata=%h required 44444444333333332222222211111111", line_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [LW-1:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    line_read = 1'b1;
    // Both requests high: write must go first, read stays held.
    run_txn(1, 1, 32'h0000_3010, wd, 1, 1, 0, 1, cyc);
    run_txn(0, 1, 32'h0000_3010, '0, 1, 1, 0, 0, cyc);
    checks++;
    if (cyc !== NB + 2 + 0 && cyc < NB + 2) begin
      errors++;
      $display("FAIL simul_read_len: cycles=%0d required >= %0d", cyc, NB + 2);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    line_write   = 1'b1;
    line_address = 32'h0000_1040;
    line_wdata   = {$urandom, $urandom, $urandom, $urandom};
    pmem_resp    = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_burst");
    line_write = 1'b0;
    pmem_resp  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_fill = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (line_resp !== 0 || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL after_reset: line_resp=%b st=%0d required 0/IDLE", line_resp, dbg_state);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    bit wr;
    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom);
      run_txn(wr, !wr, AW'($urandom), {$urandom, $urandom, $urandom, $urandom},
              3, 1, 0, 0, cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_spurious_resp();
    test_writeback();
    test_fill_stalls();
    test_simultaneous();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
